// File: rtl/main_system_nios2_fft_cpu_ocimem_pkg.sv
// Shared types and jdo field map for the Nios II FFT CPU OCI memory arbiter.
package main_system_nios2_fft_cpu_ocimem_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCpuRd  = 2'd1,
    StJtagRd = 2'd2
  } state_e;

  typedef enum logic {
    GrantCpu  = 1'b0,
    GrantJtag = 1'b1
  } grant_e;

  typedef enum logic [2:0] {
    CmdNone        = 3'd0,
    CmdSetAddr     = 3'd1,
    CmdSetAddrRead = 3'd2,
    CmdRead        = 3'd3,
    CmdWrite       = 3'd4
  } jtag_cmd_e;

  localparam int unsigned JDO_W         = 38;
  localparam int unsigned JDO_RD_BIT    = 34;
  localparam int unsigned JDO_ADDR_LSB  = 10;
  localparam int unsigned JDO_WDATA_LSB = 3;

  // Strobes should be exclusive; if not, b beats a beats no_action_a.
  function automatic jtag_cmd_e decode_cmd(input logic take_b, input logic take_a,
                                           input logic a_rd, input logic take_na);
    if (take_b) begin
      return CmdWrite;
    end else if (take_a) begin
      return a_rd ? CmdSetAddrRead : CmdSetAddr;
    end else if (take_na) begin
      return CmdRead;
    end
    return CmdNone;
  endfunction

endpackage

// File: rtl/main_system_nios2_fft_cpu_ocimem_rr2.sv
// Two-way round-robin arbiter (CPU vs JTAG); remembers the last winner.
module main_system_nios2_fft_cpu_ocimem_rr2
  import main_system_nios2_fft_cpu_ocimem_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   req_cpu,
  input  logic   req_jtag,
  output logic   gnt_valid,
  output grant_e gnt
);

  grant_e last_q;

  always_comb begin
    gnt_valid = req_cpu | req_jtag;
    if (req_cpu && req_jtag) begin
      gnt = (last_q == GrantCpu) ? GrantJtag : GrantCpu;
    end else if (req_cpu) begin
      gnt = GrantCpu;
    end else begin
      gnt = GrantJtag;
    end
  end

  // Reset to JTAG so the CPU wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= GrantJtag;
    end else if (gnt_valid) begin
      last_q <= gnt;
    end
  end

endmodule

// File: rtl/main_system_nios2_fft_cpu_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the CPU Avalon slave and queued JTAG commands.
module main_system_nios2_fft_cpu_ocimem_arbiter
  import main_system_nios2_fft_cpu_ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [DATA_W-1:0] mon_d_q, mon_d_d;
  logic              jtag_pend_q, jtag_pend_d;
  logic              jtag_wr_q, jtag_wr_d;
  logic              ready_q, ready_d;
  logic              overrun_q, overrun_d;

  logic      cpu_req;
  logic      arb_req_cpu, arb_req_jtag;
  logic      gnt_valid;
  grant_e    gnt;
  logic      cpu_grant, jtag_grant;
  logic      busy;
  jtag_cmd_e cmd;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

  assign cpu_req = avs_read | avs_write;

  // Arbitration only happens in IDLE and never while reset is held.
  assign arb_req_cpu  = reset_n && (state_q == StIdle) && cpu_req;
  assign arb_req_jtag = reset_n && (state_q == StIdle) && jtag_pend_q;

  main_system_nios2_fft_cpu_ocimem_rr2 u_rr2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_cpu   (arb_req_cpu),
    .req_jtag  (arb_req_jtag),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  assign cpu_grant  = gnt_valid && (gnt == GrantCpu);
  assign jtag_grant = gnt_valid && (gnt == GrantJtag);
  assign busy       = jtag_pend_q || (state_q == StJtagRd);
  assign cmd        = decode_cmd(take_action_ocimem_b, take_action_ocimem_a, jdo[JDO_RD_BIT],
                                 take_no_action_ocimem_a);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_grant && !avs_write) begin
          state_d = StCpuRd;
        end else if (jtag_grant && !jtag_wr_q) begin
          state_d = StJtagRd;
        end
      end
      StCpuRd:  state_d = StIdle;
      StJtagRd: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs: RAM port and Avalon handshake
  always_comb begin
    ram_addr        = mon_a_q;
    ram_wr          = 1'b0;
    ram_wdata       = mon_d_q;
    avs_readdata    = ram_rdata;
    avs_waitrequest = cpu_req;
    if (cpu_grant) begin
      ram_addr  = avs_address;
      ram_wdata = avs_writedata;
      ram_wr    = avs_write;
      if (avs_write) begin
        avs_waitrequest = 1'b0;
      end
    end else if (jtag_grant) begin
      ram_wr = jtag_wr_q;
    end
    if (state_q == StCpuRd) begin
      avs_waitrequest = 1'b0;
    end
  end

  // Monitor registers and JTAG command queue
  always_comb begin
    mon_a_d     = mon_a_q;
    mon_d_d     = mon_d_q;
    jtag_pend_d = jtag_pend_q;
    jtag_wr_d   = jtag_wr_q;
    ready_d     = ready_q;
    overrun_d   = overrun_q;

    if (jtag_grant && jtag_wr_q) begin
      mon_a_d     = mon_a_q + 1'b1;
      jtag_pend_d = 1'b0;
      ready_d     = 1'b1;
    end
    if (state_q == StJtagRd) begin
      mon_d_d     = ram_rdata;
      mon_a_d     = mon_a_q + 1'b1;
      jtag_pend_d = 1'b0;
      ready_d     = 1'b1;
    end

    // Accepted commands cannot collide with a completion: busy covers both.
    if (cmd != CmdNone) begin
      if (busy) begin
        overrun_d = 1'b1;
      end else begin
        case (cmd)
          CmdWrite: begin
            mon_d_d     = jdo[JDO_WDATA_LSB +: DATA_W];
            jtag_pend_d = 1'b1;
            jtag_wr_d   = 1'b1;
            ready_d     = 1'b0;
          end
          CmdSetAddr: begin
            mon_a_d = jdo[JDO_ADDR_LSB +: ADDR_W];
          end
          CmdSetAddrRead: begin
            mon_a_d     = jdo[JDO_ADDR_LSB +: ADDR_W];
            jtag_pend_d = 1'b1;
            jtag_wr_d   = 1'b0;
            ready_d     = 1'b0;
          end
          CmdRead: begin
            jtag_pend_d = 1'b1;
            jtag_wr_d   = 1'b0;
            ready_d     = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_a_q     <= '0;
      mon_d_q     <= '0;
      jtag_pend_q <= 1'b0;
      jtag_wr_q   <= 1'b0;
      ready_q     <= 1'b1;
      overrun_q   <= 1'b0;
    end else begin
      mon_a_q     <= mon_a_d;
      mon_d_q     <= mon_d_d;
      jtag_pend_q <= jtag_pend_d;
      jtag_wr_q   <= jtag_wr_d;
      ready_q     <= ready_d;
      overrun_q   <= overrun_d;
    end
  end

  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign jtag_overrun  = overrun_q;

endmodule

// File: tb/tb_main_system_nios2_fft_cpu_ocimem_arbiter.sv
// Self-checking bench: directed table, timing sequences and randomized traffic vs a
// transaction-level model of the monitor registers and RAM contents.
module tb_main_system_nios2_fft_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready, jtag_overrun;

  always #5 clk = ~clk;

  main_system_nios2_fft_cpu_ocimem_arbiter dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wr                  (ram_wr),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .jtag_overrun            (jtag_overrun)
  );

  function automatic logic [31:0] init_val(input int i);
    logic [7:0] a;
    a = i[7:0];
    if (i == 16) return 32'hDEADBEEF;
    if (i == 17) return 32'h11111111;
    return {16'hC0DE, 8'h00, a};
  endfunction

  // RAM with one-cycle registered read; fill restores known contents during reset.
  logic [31:0] mem [256];
  logic        fill = 1'b0;
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (ram_wr) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  typedef enum int {OpCwr, OpCrd, OpJa, OpJna, OpJb} op_e;
  typedef struct {
    op_e         op;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        rd;
    logic [31:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [256];
  logic [7:0]  model_mon_a;
  logic [31:0] model_mon_d;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual timeout required completion", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] rand_jdo();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[37:0];
  endfunction

  function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
    logic [37:0] j;
    j = rand_jdo();
    j[17:10] = a;
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = rand_jdo();
    j[34:3] = d;
    return j;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_address = '0;
    avs_writedata = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    fill = 1'b1;
    step();
    step();
    fill = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
    model_mon_a = '0;
    model_mon_d = '0;
    step();
  endtask

  // kind: 0 = action_a, 1 = no_action_a, 2 = action_b. Returns one cycle after the strobe.
  task automatic jtag_cmd(input int kind, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a = (kind == 0);
    take_no_action_ocimem_a = (kind == 1);
    take_action_ocimem_b = (kind == 2);
    step();
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = monitor_ready;
      step();
    end
    if (!ok) fail_timeout(name);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (!avs_waitrequest) done = 1'b1;
      else waits++;
      step();
    end
    avs_write = 1'b0;
    if (!done) fail_timeout("cpu_write");
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    d = 'x;
    avs_address = a;
    avs_read = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin
        d = avs_readdata;
        done = 1'b1;
      end else begin
        waits++;
      end
      step();
    end
    avs_read = 1'b0;
    if (!done) fail_timeout("cpu_read");
  endtask

  function automatic logic [31:0] predict(input op_e op, input logic [7:0] a,
                                          input logic [31:0] d, input logic rd);
    case (op)
      OpCrd:   return model_mem[a];
      OpJa:    return rd ? model_mem[a] : model_mon_d;
      OpJna:   return model_mem[model_mon_a];
      OpJb:    return d;
      default: return 32'h0;
    endcase
  endfunction

  // Uncontended serial operation; updates the model and checks result and latency.
  task automatic run_op(input op_e op, input logic [7:0] a, input logic [31:0] d,
                        input logic rd, input logic [31:0] exp);
    int          w;
    logic [31:0] r;
    case (op)
      OpCwr: begin
        cpu_write(a, d, w);
        model_mem[a] = d;
        chk32("cpu_write_waits", w, 0);
      end
      OpCrd: begin
        cpu_read(a, r, w);
        chk32("cpu_read_data", r, exp);
        chk32("cpu_read_waits", w, 1);
      end
      OpJa: begin
        jtag_cmd(0, jdo_a(a, rd));
        model_mon_a = a;
        if (rd) begin
          model_mon_d = model_mem[a];
          model_mon_a = a + 8'd1;
        end
        wait_ready("ja_ready");
        chk32("ja_mondreg", MonDReg, exp);
      end
      OpJna: begin
        jtag_cmd(1, rand_jdo());
        model_mon_d = model_mem[model_mon_a];
        model_mon_a = model_mon_a + 8'd1;
        wait_ready("jna_ready");
        chk32("jna_mondreg", MonDReg, exp);
      end
      OpJb: begin
        jtag_cmd(2, jdo_b(d));
        model_mem[model_mon_a] = d;
        model_mon_d = d;
        model_mon_a = model_mon_a + 8'd1;
        wait_ready("jb_ready");
        chk32("jb_mondreg", MonDReg, exp);
      end
      default: ;
    endcase
  endtask

  vec_t vecs[14];

  initial begin
    int          w;
    logic [31:0] r;

    vecs[0]  = '{OpCwr, 8'h20, 32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[1]  = '{OpCrd, 8'h20, 32'h0, 1'b0, 32'hA5A5A5A5};
    vecs[2]  = '{OpJa,  8'h10, 32'h0, 1'b1, 32'hDEADBEEF};
    vecs[3]  = '{OpJna, 8'h00, 32'h0, 1'b0, 32'h11111111};
    vecs[4]  = '{OpJa,  8'hFF, 32'h0, 1'b0, 32'h11111111};
    vecs[5]  = '{OpJb,  8'h00, 32'h1, 1'b0, 32'h1};
    vecs[6]  = '{OpJb,  8'h00, 32'h2, 1'b0, 32'h2};
    vecs[7]  = '{OpJb,  8'h00, 32'h3, 1'b0, 32'h3};
    vecs[8]  = '{OpCrd, 8'hFF, 32'h0, 1'b0, 32'h1};
    vecs[9]  = '{OpCrd, 8'h00, 32'h0, 1'b0, 32'h2};
    vecs[10] = '{OpCrd, 8'h01, 32'h0, 1'b0, 32'h3};
    vecs[11] = '{OpJna, 8'h00, 32'h0, 1'b0, 32'hC0DE0002};
    vecs[12] = '{OpJa,  8'h20, 32'h0, 1'b1, 32'hA5A5A5A5};
    vecs[13] = '{OpJa,  8'h00, 32'h0, 1'b1, 32'h2};

    // Reset values
    do_reset();
    @(negedge clk);
    chk1("rst_ready", monitor_ready, 1'b1);
    chk32("rst_mondreg", MonDReg, 32'h0);
    chk1("rst_overrun", jtag_overrun, 1'b0);
    chk1("rst_waitreq", avs_waitrequest, 1'b0);
    chk1("rst_ram_wr", ram_wr, 1'b0);
    step();

    // Directed table
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].rd, vecs[i].exp);
    end

    // JTAG read latency: ready low t+1..t+2, MonDReg valid and ready high at t+3
    do_reset();
    jtag_cmd(0, jdo_a(8'h10, 1'b1));
    @(negedge clk);
    chk1("rdlat_ready_t1", monitor_ready, 1'b0);
    chk32("rdlat_addr_t1", ram_addr, 32'h10);
    step();
    @(negedge clk);
    chk1("rdlat_ready_t2", monitor_ready, 1'b0);
    step();
    @(negedge clk);
    chk1("rdlat_ready_t3", monitor_ready, 1'b1);
    chk32("rdlat_mondreg_t3", MonDReg, 32'hDEADBEEF);
    step();
    model_mon_a = 8'h11;
    model_mon_d = 32'hDEADBEEF;
    run_op(OpJna, 8'h0, 32'h0, 1'b0, 32'h11111111);

    // JTAG write latency: ram_wr at t+1, ready at t+2
    run_op(OpJa, 8'h33, 32'h0, 1'b0, 32'h11111111);
    jtag_cmd(2, jdo_b(32'hCAFE0033));
    @(negedge clk);
    chk1("wrlat_ram_wr_t1", ram_wr, 1'b1);
    chk32("wrlat_addr_t1", ram_addr, 32'h33);
    chk32("wrlat_wdata_t1", ram_wdata, 32'hCAFE0033);
    chk1("wrlat_ready_t1", monitor_ready, 1'b0);
    step();
    @(negedge clk);
    chk1("wrlat_ready_t2", monitor_ready, 1'b1);
    step();
    model_mem[8'h33] = 32'hCAFE0033;
    model_mon_a = 8'h34;
    model_mon_d = 32'hCAFE0033;
    run_op(OpCrd, 8'h33, 32'h0, 1'b0, 32'hCAFE0033);

    // Overrun: second strobe one cycle after the first is dropped
    do_reset();
    run_op(OpJa, 8'h40, 32'h0, 1'b0, 32'h0);
    jtag_cmd(2, jdo_b(32'h12345678));
    jtag_cmd(0, jdo_a(8'h80, 1'b1));
    @(negedge clk);
    chk1("ovr_flag", jtag_overrun, 1'b1);
    step();
    wait_ready("ovr_ready");
    repeat (3) step();
    @(negedge clk);
    chk32("ovr_mondreg", MonDReg, 32'h12345678);
    chk1("ovr_ready_idle", monitor_ready, 1'b1);
    step();
    model_mem[8'h40] = 32'h12345678;
    model_mon_a = 8'h41;
    model_mon_d = 32'h12345678;
    run_op(OpCrd, 8'h40, 32'h0, 1'b0, 32'h12345678);
    run_op(OpJna, 8'h0, 32'h0, 1'b0, 32'hC0DE0041);
    chk1("ovr_sticky", jtag_overrun, 1'b1);

    // Asynchronous reset while in JTAG_RD
    do_reset();
    run_op(OpJa, 8'h10, 32'h0, 1'b1, 32'hDEADBEEF);
    jtag_cmd(0, jdo_a(8'h20, 1'b1));
    step();
    avs_write = 1'b1;
    avs_address = 8'h50;
    avs_writedata = 32'hFFFFFFFF;
    reset_n = 1'b0;
    #1;
    chk32("arst_mondreg", MonDReg, 32'h0);
    chk1("arst_ready", monitor_ready, 1'b1);
    chk1("arst_overrun", jtag_overrun, 1'b0);
    chk1("arst_ram_wr", ram_wr, 1'b0);
    chk1("arst_waitreq_req", avs_waitrequest, 1'b1);
    avs_write = 1'b0;
    #1;
    chk1("arst_waitreq_idle", avs_waitrequest, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    @(negedge clk);
    chk32("arst_mondreg_after", MonDReg, 32'h0);
    chk1("arst_ready_after", monitor_ready, 1'b1);
    step();
    model_mon_a = 8'h00;
    model_mon_d = 32'h0;
    run_op(OpCrd, 8'h50, 32'h0, 1'b0, 32'hC0DE0050);
    run_op(OpJna, 8'h0, 32'h0, 1'b0, 32'hC0DE0000);

    // Tie after reset: CPU first, then JTAG, CPU stalls for the JTAG read only
    do_reset();
    jtag_cmd(1, rand_jdo());
    avs_read = 1'b1;
    avs_address = 8'h30;
    @(negedge clk);
    chk1("tie_t1_wait", avs_waitrequest, 1'b1);
    chk32("tie_t1_addr", ram_addr, 32'h30);
    step();
    @(negedge clk);
    chk1("tie_t2_wait", avs_waitrequest, 1'b0);
    chk32("tie_t2_data", avs_readdata, 32'hC0DE0030);
    step();
    @(negedge clk);
    chk1("tie_t3_wait", avs_waitrequest, 1'b1);
    chk32("tie_t3_addr", ram_addr, 32'h00);
    step();
    @(negedge clk);
    chk1("tie_t4_wait", avs_waitrequest, 1'b1);
    step();
    @(negedge clk);
    chk1("tie_t5_wait", avs_waitrequest, 1'b1);
    chk1("tie_t5_ready", monitor_ready, 1'b1);
    chk32("tie_t5_mondreg", MonDReg, 32'hC0DE0000);
    chk32("tie_t5_addr", ram_addr, 32'h30);
    step();
    @(negedge clk);
    chk1("tie_t6_wait", avs_waitrequest, 1'b0);
    chk32("tie_t6_data", avs_readdata, 32'hC0DE0030);
    step();
    avs_read = 1'b0;
    step();

    // Randomized serial traffic against the model
    do_reset();
    for (int i = 0; i < 150; i++) begin
      op_e         op;
      logic [7:0]  a;
      logic [31:0] d;
      logic        rd;
      op = op_e'($urandom_range(0, 4));
      a  = 8'($urandom_range(0, 255));
      d  = $urandom;
      rd = 1'($urandom_range(0, 1));
      run_op(op, a, d, rd, predict(op, a, d, rd));
    end
    @(negedge clk);
    chk1("rand_no_overrun", jtag_overrun, 1'b0);
    step();

    // Randomized contention: CPU reads back-to-back while JTAG reads whenever ready
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [7:0]  ca;
          logic [31:0] cd;
          int          cw;
          ca = 8'($urandom_range(0, 255));
          cpu_read(ca, cd, cw);
          chk32("cont_cpu_data", cd, model_mem[ca]);
          chk1("cont_cpu_wait_bound", cw <= 3, 1'b1);
        end
      end
      begin
        for (int j = 0; j < 12; j++) begin
          logic [31:0] jexp;
          logic [7:0]  ja;
          if ($urandom_range(0, 1) == 1) begin
            ja = 8'($urandom_range(0, 255));
            jexp = model_mem[ja];
            jtag_cmd(0, jdo_a(ja, 1'b1));
            model_mon_a = ja + 8'd1;
          end else begin
            jexp = model_mem[model_mon_a];
            jtag_cmd(1, rand_jdo());
            model_mon_a = model_mon_a + 8'd1;
          end
          wait_ready("cont_jtag_ready");
          chk32("cont_jtag_mondreg", MonDReg, jexp);
        end
      end
    join
    @(negedge clk);
    chk1("cont_no_overrun", jtag_overrun, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
